// File: rtl/key_debounce.sv
// key_debounce: turns a raw, bouncy, active-low DE2 pushbutton into a clean
// debounced level, single-cycle press/release pulses, a wrapping press counter
// and an LED mirror.
// Optional build macro LONG_PRESS_EN adds a one-shot long-press pulse after the
// key has been held LONG_CYCLES cycles; without it long_press is tied to 0.
// The release pulse port is named release_pulse because "release" is a
// reserved word in SystemVerilog.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 8,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             KEY,
  output logic             pressed,
  output logic             press,
  output logic             release_pulse,
  output logic [CNT_W-1:0] press_count,
  output logic             LEDG,
  output logic             long_press
);

  localparam int            DW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  // Both counters below rely on at least two cycles of qualification.
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_cfg
    $error("key_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, ARM_P, PRESSED, ARM_R} state_t;

  state_t             state, state_d;
  logic               s1, s;
  logic [DW-1:0]      cnt, cnt_d;
  logic               pressed_d, press_d, release_d;
  logic [CNT_W-1:0]   press_count_d;

  // Two-flop synchronizer; idles at 1 (released) so reset never looks like a press.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1 <= 1'b1;
      s  <= 1'b1;
    end else begin
      s1 <= KEY;
      s  <= s1;
    end
  end

  // State register plus registered outputs of the debounce FSM.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      cnt           <= '0;
      pressed       <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      pressed       <= pressed_d;
      press         <= press_d;
      release_pulse <= release_d;
      press_count   <= press_count_d;
    end
  end

  // Next state: each edge must hold DEBOUNCE_CYCLES+1 synchronized samples to be accepted.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    pressed_d     = pressed;
    press_d       = 1'b0;
    release_d     = 1'b0;
    press_count_d = press_count;
    case (state)
      IDLE: begin
        if (!s) begin
          state_d = ARM_P;
          cnt_d   = '0;
        end
      end
      ARM_P: begin
        if (s) begin
          state_d = IDLE;
        end else if (cnt == DB_MAX) begin
          state_d       = PRESSED;
          press_d       = 1'b1;
          pressed_d     = 1'b1;
          press_count_d = press_count + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (s) begin
          state_d = ARM_R;
          cnt_d   = '0;
        end
      end
      ARM_R: begin
        if (!s) begin
          state_d = PRESSED;
        end else if (cnt == DB_MAX) begin
          state_d   = IDLE;
          release_d = 1'b1;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign LEDG = pressed;

`ifdef LONG_PRESS_EN
  localparam int            LW     = $clog2(LONG_CYCLES);
  localparam logic [LW-1:0] LP_MAX = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] hold_cnt;
  logic          long_done;

  // Hold timer runs while the key is accepted as held (including release qualification);
  // long_done keeps it to one pulse per accepted press.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_cnt   <= '0;
      long_done  <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      case (state)
        IDLE: begin
          hold_cnt  <= '0;
          long_done <= 1'b0;
        end
        ARM_P: hold_cnt <= '0;
        default: begin
          if (hold_cnt == LP_MAX) begin
            if (!long_done) begin
              long_press <= 1'b1;
              long_done  <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule
